// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive parser.
package eth_pkg;

  localparam int ETH_HDR_LEN = 14;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef enum logic [1:0] {
    HDR,
    WAIT_HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

  // One payload byte travelling through the output register
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_beat_t;

  // Statistics counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_byte_reg.sv
// One-entry valid/ready register for payload bytes; refill allowed in the
// same cycle as a drain so the stream keeps one byte per cycle.
module eth_byte_reg
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  byte_beat_t in_beat,
  output logic       in_ready,
  output logic       out_valid,
  output byte_beat_t out_beat,
  input  logic       out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load on accept, otherwise empty on drain; the beat holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet receive parser: splits a raw byte stream into a header handshake
// (dst/src/ethertype) and a payload byte stream, dropping runts and
// truncating frames longer than MAX_LEN bytes.
module eth_rx_parser
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        hdr_valid,
  output mac_addr_t   dst_mac,
  output mac_addr_t   src_mac,
  output ethertype_t  ethertype,
  input  logic        hdr_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frame_cnt,
  output logic [15:0] runt_cnt,
  output logic [15:0] trunc_cnt
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] DST_END  = CW'(6);
  localparam logic [CW-1:0] SRC_END  = CW'(12);
  localparam logic [CW-1:0] HDR_LAST = CW'(ETH_HDR_LEN - 1);
  localparam logic [CW-1:0] LEN_LAST = CW'(MAX_LEN - 1);

  rx_state_t  state;
  logic [CW-1:0] cnt;
  logic       acc;
  logic       push;
  logic       reg_ready;
  byte_beat_t push_beat;
  byte_beat_t out_beat;

  // Payload only advances when the output register has room this cycle
  assign in_ready = !rst && ((state == HDR) || (state == DROP) ||
                             ((state == PAYLOAD) && reg_ready));
  assign acc  = in_valid && in_ready;
  assign push = acc && (state == PAYLOAD);

  // The byte at the length limit closes the emitted stream even without in_last
  assign push_beat = '{data: in_data, last: (in_last || (cnt == LEN_LAST))};

  eth_byte_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_beat   (push_beat),
    .in_ready  (reg_ready),
    .out_valid (out_valid),
    .out_beat  (out_beat),
    .out_ready (out_ready)
  );

  assign out_data = out_beat.data;
  assign out_last = out_beat.last;

  // Frame FSM: header capture, header handshake, payload pass, overflow drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HDR;
      cnt       <= '0;
      hdr_valid <= 1'b0;
      dst_mac   <= '0;
      src_mac   <= '0;
      ethertype <= '0;
      frame_cnt <= '0;
      runt_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      case (state)
        HDR: begin
          if (acc) begin
            if (cnt < DST_END)      dst_mac   <= {dst_mac[39:0], in_data};
            else if (cnt < SRC_END) src_mac   <= {src_mac[39:0], in_data};
            else                    ethertype <= {ethertype[7:0], in_data};
            if (in_last) begin
              runt_cnt <= sat_inc(runt_cnt);
              cnt      <= '0;
            end else if (cnt == HDR_LAST) begin
              state     <= WAIT_HDR;
              hdr_valid <= 1'b1;
              cnt       <= cnt + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_HDR: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (acc) begin
            if (in_last) begin
              frame_cnt <= sat_inc(frame_cnt);
              cnt       <= '0;
              state     <= HDR;
            end else if (cnt == LEN_LAST) begin
              trunc_cnt <= sat_inc(trunc_cnt);
              state     <= DROP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (acc && in_last) begin
            cnt   <= '0;
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Bench for eth_rx_parser: two instances (MAX_LEN 1518 and 32) exercised one
// at a time; a frame-level model predicts headers, payload bytes and counters.
module tb_eth_rx_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid  [2] = '{1'b0, 1'b0};
  logic [7:0]  in_data   [2] = '{8'h00, 8'h00};
  logic        in_last   [2] = '{1'b0, 1'b0};
  logic        in_ready  [2];
  logic        hdr_valid [2];
  logic [47:0] dst_mac   [2];
  logic [47:0] src_mac   [2];
  logic [15:0] ethertype [2];
  logic        hdr_ready [2] = '{1'b1, 1'b1};
  logic        out_valid [2];
  logic [7:0]  out_data  [2];
  logic        out_last  [2];
  logic        out_ready [2] = '{1'b1, 1'b1};
  logic [15:0] frame_cnt [2];
  logic [15:0] runt_cnt  [2];
  logic [15:0] trunc_cnt [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      eth_rx_parser #(.MAX_LEN(g == 0 ? 1518 : 32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[g]), .in_data(in_data[g]), .in_last(in_last[g]),
        .in_ready(in_ready[g]),
        .hdr_valid(hdr_valid[g]), .dst_mac(dst_mac[g]), .src_mac(src_mac[g]),
        .ethertype(ethertype[g]), .hdr_ready(hdr_ready[g]),
        .out_valid(out_valid[g]), .out_data(out_data[g]), .out_last(out_last[g]),
        .out_ready(out_ready[g]),
        .frame_cnt(frame_cnt[g]), .runt_cnt(runt_cnt[g]), .trunc_cnt(trunc_cnt[g])
      );
    end
  endgenerate

  localparam logic [111:0] FIXED_HDR = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800};

  int n_chk = 0;
  int n_fail = 0;
  int hmode = 0;        // 0 ready, 1 random, 2 manual
  int omode = 0;        // 0 ready, 1 toggle, 2 random, 3 manual
  logic hr_man = 1'b0;
  logic or_man = 1'b0;

  logic [7:0]   frame_b [$];
  logic [111:0] hdr_q [$];
  logic [8:0]   pay_q [$];
  int exp_frame [2] = '{0, 0};
  int exp_runt  [2] = '{0, 0};
  int exp_trunc [2] = '{0, 0};
  int obs_hdr   [2] = '{0, 0};
  int obs_pay   [2] = '{0, 0};

  typedef struct {
    int d; int len; bit fixed; bit gap; int hm; int om; int exp_hdr; int exp_pay;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int max_len(input int d);
    return (d == 0) ? 1518 : 32;
  endfunction

  // Handshake drivers for hdr_ready / out_ready
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      case (hmode)
        0: hdr_ready[d] = 1'b1;
        1: hdr_ready[d] = 1'($urandom_range(0, 1));
        default: hdr_ready[d] = hr_man;
      endcase
      case (omode)
        0: out_ready[d] = 1'b1;
        1: out_ready[d] = !out_ready[d];
        2: out_ready[d] = 1'($urandom_range(0, 1));
        default: out_ready[d] = or_man;
      endcase
    end
  end

  // Monitor: scoreboard transfers and check stability while stalled
  logic        ps [2] = '{1'b0, 1'b0};
  logic [8:0]  pv [2];
  logic        hs [2] = '{1'b0, 1'b0};
  logic [111:0] hv [2];
  logic [8:0]   e_p;
  logic [111:0] e_h;
  initial forever begin
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ps[d] = 1'b0;
        hs[d] = 1'b0;
      end else begin
        if (ps[d]) begin
          check("out_hold_valid", out_valid[d], 1'b1);
          check("out_hold_data", {out_last[d], out_data[d]}, pv[d]);
        end
        if (hs[d]) check("hdr_hold", {hdr_valid[d], dst_mac[d], src_mac[d], ethertype[d]}, {1'b1, hv[d]});
        if (out_valid[d] && out_ready[d]) begin
          obs_pay[d]++;
          if (pay_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL out_extra: got %0h, want none", {out_last[d], out_data[d]});
          end else begin
            e_p = pay_q.pop_front();
            check("out_byte", {out_last[d], out_data[d]}, e_p);
          end
        end
        if (hdr_valid[d] && hdr_ready[d]) begin
          obs_hdr[d]++;
          if (hdr_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL hdr_extra: got %0h, want none", {dst_mac[d], src_mac[d], ethertype[d]});
          end else begin
            e_h = hdr_q.pop_front();
            check("hdr_fields", {dst_mac[d], src_mac[d], ethertype[d]}, e_h);
          end
        end
        ps[d] = out_valid[d] && !out_ready[d];
        pv[d] = {out_last[d], out_data[d]};
        hs[d] = hdr_valid[d] && !hdr_ready[d];
        hv[d] = {dst_mac[d], src_mac[d], ethertype[d]};
      end
    end
  end

  task automatic build(input int len, input bit fixed);
    logic [111:0] fh;
    fh = FIXED_HDR;
    frame_b.delete();
    for (int i = 0; i < len; i++)
      if (fixed && i < 14) frame_b.push_back(fh[111-8*i -: 8]);
      else frame_b.push_back(8'($urandom));
  endtask

  // Frame-level reference: runt if it ends within the header, otherwise the
  // header goes out once and the payload is cut at max_len bytes total
  task automatic model(input int d);
    int len, n;
    logic [111:0] h;
    len = frame_b.size();
    if (len <= 14) begin
      exp_runt[d]++;
      return;
    end
    h = '0;
    for (int i = 0; i < 14; i++) h = {h[103:0], frame_b[i]};
    hdr_q.push_back(h);
    n = (len <= max_len(d)) ? len : max_len(d);
    for (int i = 14; i < n; i++) pay_q.push_back({(i == n - 1), frame_b[i]});
    if (len <= max_len(d)) exp_frame[d]++;
    else exp_trunc[d]++;
  endtask

  task automatic push_byte(input int d, input logic [7:0] b, input logic l, input bit gap);
    int n;
    if (gap && $urandom_range(0, 2) == 0) begin
      @(negedge clk);
      in_valid[d] = 1'b0;
    end
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    in_last[d]  = l;
    n = 0;
    #1;
    while (!in_ready[d]) begin
      n++;
      if (n > 300) begin
        n_chk++; n_fail++;
        $display("FAIL in_ready_timeout: got 0, want 1 within 300 cycles");
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int d, input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) push_byte(d, frame_b[i], (i == frame_b.size() - 1), gap);
  endtask

  task automatic idle_in(input int d);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pay_q.size() != 0 || hdr_q.size() != 0 || out_valid[0] || out_valid[1]) && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain", pay_q.size() + hdr_q.size(), 0);
  endtask

  task automatic check_cnts(input int d, input string tag);
    check({tag, "_frame_cnt"}, frame_cnt[d], exp_frame[d]);
    check({tag, "_runt_cnt"},  runt_cnt[d],  exp_runt[d]);
    check({tag, "_trunc_cnt"}, trunc_cnt[d], exp_trunc[d]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 64, 1'b1, 1'b0, 0, 0, 1, 50};
    vecs[1]  = '{0, 10, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[2]  = '{0, 14, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[3]  = '{0, 15, 1'b0, 1'b0, 0, 0, 1, 1};
    vecs[4]  = '{0, 30, 1'b0, 1'b0, 0, 1, 1, 16};
    vecs[5]  = '{0, 40, 1'b0, 1'b1, 1, 2, 1, 26};
    vecs[6]  = '{1, 40, 1'b0, 1'b0, 0, 0, 1, 18};
    vecs[7]  = '{1, 32, 1'b0, 1'b0, 0, 1, 1, 18};
    vecs[8]  = '{1, 33, 1'b0, 1'b1, 1, 2, 1, 18};
    vecs[9]  = '{1, 20, 1'b0, 1'b0, 0, 0, 1, 6};
    vecs[10] = '{1, 14, 1'b0, 1'b1, 0, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", in_ready[d], 1'b0);
      check("rst_out", {out_valid[d], out_last[d], hdr_valid[d]}, 3'b000);
      check("rst_fields", {dst_mac[d], src_mac[d], ethertype[d]}, 112'h0);
      check_cnts(d, "rst");
    end
    rst = 1'b0;

    // Table of single frames
    for (int v = 0; v < 11; v++) begin
      hmode = vecs[v].hm;
      omode = vecs[v].om;
      obs_hdr[vecs[v].d] = 0;
      obs_pay[vecs[v].d] = 0;
      build(vecs[v].len, vecs[v].fixed);
      model(vecs[v].d);
      send_range(vecs[v].d, 0, vecs[v].len, vecs[v].gap);
      idle_in(vecs[v].d);
      wait_drain();
      check($sformatf("v%0d_hdr_count", v), obs_hdr[vecs[v].d], vecs[v].exp_hdr);
      check($sformatf("v%0d_pay_count", v), obs_pay[vecs[v].d], vecs[v].exp_pay);
      check_cnts(vecs[v].d, $sformatf("v%0d", v));
    end

    // Next header accepted while the previous out_last byte is still pending
    hmode = 0; omode = 3; or_man = 1'b0;
    build(15, 1'b0);
    model(0);
    send_range(0, 0, 15, 1'b0);
    build(20, 1'b0);
    model(0);
    send_range(0, 0, 14, 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    check("pend_out_valid", {out_valid[0], out_last[0]}, 2'b11);
    or_man = 1'b1;
    send_range(0, 14, 20, 1'b0);
    idle_in(0);
    wait_drain();
    check_cnts(0, "pend");

    // Back-to-back frames, in_valid held, out_ready toggling
    omode = 1;
    obs_pay[0] = 0;
    build(20, 1'b0); model(0); send_range(0, 0, 20, 1'b0);
    build(25, 1'b0); model(0); send_range(0, 0, 25, 1'b0);
    idle_in(0);
    wait_drain();
    check("b2b_pay_count", obs_pay[0], 17);
    check_cnts(0, "b2b");

    // Header handshake held off for 5 cycles
    omode = 0; hmode = 2; hr_man = 1'b0;
    build(20, 1'b0);
    model(0);
    send_range(0, 0, 14, 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = frame_b[14]; in_last[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("hold%0d_hdr_valid", k), hdr_valid[0], 1'b1);
      check($sformatf("hold%0d_in_ready", k), in_ready[0], 1'b0);
      if (k == 4) hr_man = 1'b1;
      @(negedge clk);
    end
    #1;
    check("hs_cycle_in_ready", in_ready[0], 1'b0);
    hr_man = 1'b0;
    @(negedge clk);
    #1;
    check("payload_start_in_ready", {in_ready[0], hdr_valid[0]}, 2'b10);
    send_range(0, 15, 20, 1'b0);
    idle_in(0);
    wait_drain();
    hmode = 0;
    check_cnts(0, "hold");

    // Reset pulsed after payload byte 5
    build(30, 1'b0);
    begin
      logic [111:0] h;
      h = '0;
      for (int i = 0; i < 14; i++) h = {h[103:0], frame_b[i]};
      hdr_q.push_back(h);
      for (int i = 14; i < 19; i++) pay_q.push_back({1'b0, frame_b[i]});
    end
    send_range(0, 0, 20, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid[0] = 1'b0;
    #1;
    check("midrst_in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    #1;
    check("midrst_out_valid", {out_valid[0], hdr_valid[0]}, 2'b00);
    for (int d = 0; d < 2; d++) begin
      exp_frame[d] = 0; exp_runt[d] = 0; exp_trunc[d] = 0;
    end
    check_cnts(0, "midrst");
    check("midrst_q", pay_q.size() + hdr_q.size(), 0);
    rst = 1'b0;
    obs_pay[0] = 0;
    build(20, 1'b0);
    model(0);
    send_range(0, 0, 20, 1'b0);
    idle_in(0);
    wait_drain();
    check("postrst_pay_count", obs_pay[0], 6);
    check_cnts(0, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum accepted frame length in bytes, header included, no FCS.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1, in_data input 8, in_last input 1: the byte stream from the raw-socket receive source, with in_last marking the final byte of a frame.
REQ-005 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-006 SHALL have ports hdr_valid output 1, dst_mac output 48, src_mac output 48, ethertype output 16, hdr_ready input 1: the parsed-header handshake.
REQ-007 SHALL have ports out_valid output 1, out_data output 8, out_last output 1, out_ready input 1: the payload byte stream.
REQ-008 SHALL have ports frame_cnt, runt_cnt, trunc_cnt, each output 16: saturating counters of good, runt and truncated frames.

Function
REQ-009 SHALL implement the states HDR, WAIT_HDR, PAYLOAD and DROP.
REQ-010 In HDR, in_ready SHALL be 1; the byte counter SHALL increment per accepted byte, and bytes 0-5, 6-11 and 12-13 SHALL be shifted MSB-first into dst_mac, src_mac and ethertype respectively.
REQ-011 If in_last arrives on any header byte 0-13, the frame SHALL be a runt: no hdr_valid, runt_cnt +1, counter cleared, state stays HDR.
REQ-012 On accepting byte 13 without in_last: state to WAIT_HDR; hdr_valid=1 from the next cycle.
REQ-013 In WAIT_HDR: in_ready=0, hdr_valid=1, header fields stable; on hdr_ready=1 go to PAYLOAD the next cycle.
REQ-014 In PAYLOAD, payload bytes SHALL pass through a one-entry output register, giving 1-cycle latency from input acceptance to out_valid.
REQ-015 In PAYLOAD: in_ready = !out_valid || out_ready; a simultaneous drain and refill of the output register SHALL sustain 1 byte/cycle.
REQ-016 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-017 Accepting an in_last byte in PAYLOAD SHALL register it with out_last=1, frame_cnt +1, clear the counter, and return to HDR.
REQ-018 When the accepted byte is number MAX_LEN-1 (0-based) without in_last: register it with out_last=1, trunc_cnt +1, go to DROP.
REQ-019 In DROP: in_ready=1, bytes discarded, no outputs driven valid; on an accepted in_last byte, clear the counter and return to HDR.
REQ-020 A new frame's header bytes SHALL be accepted in HDR while the previous out_last byte is still pending in the output register.
REQ-021 Byte counter SHALL be $clog2(MAX_LEN+1) bits; counters SHALL saturate at 16'hFFFF, never wrap.
REQ-022 out_valid SHALL never be asserted in HDR, WAIT_HDR or DROP unless carrying a byte registered before leaving PAYLOAD.

Reset
REQ-023 On rst=1 at posedge: state HDR, byte counter 0, out_valid 0, out_last 0, hdr_valid 0, all three counters 0, dst_mac/src_mac/ethertype 0.
REQ-024 rst mid-frame SHALL discard the frame: no counter increment, no out_last emitted; the next byte after rst deasserts is treated as byte 0.
REQ-025 in_ready SHALL be 0 while rst=1.

Structure
REQ-026 Package eth_pkg SHALL hold ETH_HDR_LEN=14, types mac_addr_t (48 bits) and ethertype_t (16 bits), and the state enum rx_state_t.
REQ-027 The output register SHALL be a sub-module eth_byte_reg (data+last, valid/ready).

Verification
REQ-028 64-byte frame, dst FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800, hdr_ready/out_ready=1 -> header fields exact; 50 payload bytes in order; out_last on the 50th; frame_cnt=1.
REQ-029 10-byte frame with in_last on byte 9 -> no hdr_valid, no out_valid, runt_cnt=1; a following 14-byte frame -> runt_cnt=2.
REQ-030 MAX_LEN=32, 40-byte frame -> 18 payload bytes, out_last on the 18th, trunc_cnt=1, remaining 8 bytes dropped; next frame parses normally.
REQ-031 hdr_ready held 0 for 5 cycles -> hdr_valid high, fields stable and in_ready=0 throughout; payload starts the cycle after hdr_ready=1.
REQ-032 out_ready toggling 1010... in PAYLOAD -> no byte lost or duplicated, data stable while stalled; back-to-back frames with in_valid=1 continuously -> both frames are parsed correctly.
REQ-033 rst pulsed after payload byte 5 of a frame -> counters 0, out_valid 0 next cycle, the next frame is parsed from its first byte.
